ipsl_pcie_dbi_responder: RTL and testbench
==========================================

# ipsl_pcie_dbi_responder

DBI-side responder for the PCIe configuration path: it sits on the far end of the APB-to-DBI bridge and answers its `dbi_cs`/`dbi_wr` requests with `lbc_dbi_ack`, `lbc_dbi_dout` and `dbi_halt`. It holds a 64-word shadow configuration bank with byte-enable writes, read-only word protection, programmable ack latency and a busy/retry (halt) mechanism. It serves as the local-bus-controller stand-in for bring-up and as the soft shadow for registers that the hard core does not implement.

## Interface
- `ACK_LAT`, default 2: cycles from request capture to ack; legal range 1..15.
- `RO_WORDS`, default 4: words 0..RO_WORDS-1 of bank 1 are read-only.
- `ID_VAL`, default 32'h5A5A_0001: reset value of bank-1 word 0. All other words reset to 0.
- `pclk_div2` input 1: the single clock.
- `apb_rst` input 1: reset. Synchronous, active-high.
- `dbi_addr` input 32: byte address. Bits [7:2] select the word. Bits [11:8] must be zero to hit; any other value misses.
- `dbi_din` input 32: write data.
- `dbi_cs` input 1: request. The master holds it high until it sees ack.
- `dbi_cs2` input 1: bank-2 select, sampled at capture.
- `dbi_wr` input 4: byte strobes, valid only in the first cycle of `dbi_cs`. Nonzero means write; zero means read.
- `app_dbi_ro_wr_disable` input 1: sampled at capture. High blocks writes to read-only words.
- `cfg_busy` input 1: sampled in the ack cycle. High forces a halt.
- `lbc_dbi_ack` output 1: one-cycle completion pulse.
- `lbc_dbi_dout` output 32: read data, valid in the ack cycle.
- `dbi_halt` output 1: retry indication, qualified by ack.
- `halt_cnt` output 8: saturating count of halted accesses.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **Capture.** Capture happens on the rising edge of `dbi_cs`, i.e. `dbi_cs & !cs_q`, with the FSM in IDLE.
  - Latch the address word, the hit flag, `dbi_din`, `dbi_wr`, `dbi_cs2` and `app_dbi_ro_wr_disable`.
  - Load the latency counter with ACK_LAT-1.
  - Go to WAIT, or directly to ACK when ACK_LAT=1.
- **WAIT.** Decrement the counter; go to ACK when it reaches 0.
- **ACK.**
  - Assert `lbc_dbi_ack` for exactly one cycle.
  - `dbi_halt` equals `cfg_busy` in this cycle.
  - Return to IDLE.
- **Commit** happens in the ACK cycle only, when all of the following hold:
  - not halted;
  - hit;
  - strobes nonzero;
  - not (bank 1, word < RO_WORDS, ro-disable latched high).
  - Each byte lane is written iff its strobe bit is set.
- **Read data.**
  - `lbc_dbi_dout` carries the addressed word (pre-write value) in the ACK cycle.
  - It is 0 on a miss, on a halt, on a write, and in every non-ACK cycle.
- **Halted access.**
  - No state changes.
  - `halt_cnt` increments and saturates at 255.
  - The master re-requests with a fresh `dbi_cs` rising edge.
- **Holding `dbi_cs`.** A `dbi_cs` held high after ack, or a level-high `dbi_cs` with no new edge, starts nothing.
- **Early release.** If `dbi_cs` drops before ack, the access still completes and acks, because it is captured at the edge.

## Timing
- Reset values: `lbc_dbi_ack`=0, `lbc_dbi_dout`=0, `dbi_halt`=0, `halt_cnt`=0. FSM=IDLE, `cs_q`=0, bank word 0 = ID_VAL, all other words 0.
- Latency: the edge seen in cycle T gives ack in cycle T+ACK_LAT.
- The written value is visible to a read captured at T+ACK_LAT+1 or later.
- Back-to-back: the earliest next capture is the cycle after ack. With the master rule of dropping `dbi_cs` after ack, the minimum request spacing is ACK_LAT+2 cycles.
- Reset asserted mid-access: the FSM returns to IDLE, no commit, no ack, and the register contents return to reset values.
- A `cfg_busy` change during WAIT has no effect; only the ACK-cycle value counts.

## Configuration
- Macro `IPSL_PCIE_DBI_BANK2_EN`.
- **Defined:** `dbi_cs2`=1 accesses a second 64-word bank, reset 0, with no read-only words. It is used as the write-mask shadow.
- **Undefined:** bank 2 is not built. `dbi_cs2`=1 accesses ack normally (halt rules still apply), read 0, and drop writes.

## Test plan
- **Reset read.** Reset, then read bank 1 addr 0x000 -> ack 2 cycles after the cs edge, dout=32'h5A5A_0001, halt=0.
- **Byte-lane write.**
  - Write 32'hDEAD_BEEF with strobes 4'b0101 to addr 0x010.
  - Read addr 0x010 -> 32'h00AD_00EF.
- **Read-only protection.**
  - Write 32'hFFFF_FFFF with strobes 4'hF to addr 0x004, ro-disable=1 -> readback 0.
  - Repeat with ro-disable=0 -> readback 32'hFFFF_FFFF.
- **Halt/retry.**
  - Write 32'h1234_5678 to addr 0x020 with `cfg_busy`=1 in the ack cycle -> ack with halt=1, `halt_cnt`=1, readback 0.
  - Retry with `cfg_busy`=0 -> readback 32'h1234_5678.
- **Miss.** Access addr 0x104 -> ack, dout=0, and no bank word changes (checked by reading back all 64 words).
- **Bank 2 and latency.**
  - ACK_LAT=5: the cs2 write 32'hA5A5_A5A5 to addr 0x000 acks at T+5.
  - With the macro defined: bank-2 read returns 32'hA5A5_A5A5 and bank-1 word 0 stays 32'h5A5A_0001.
  - Without the macro: the bank-2 read returns 0.

Source files
------------

// File: rtl/ipsl_pcie_dbi_responder_if.sv
// rtl/ipsl_pcie_dbi_responder_if.sv - DBI request/response bundle between bridge master and responder
interface ipsl_pcie_dbi_responder_if;
    logic [31:0] dbi_addr;
    logic [31:0] dbi_din;
    logic        dbi_cs;
    logic        dbi_cs2;
    logic [3:0]  dbi_wr;
    logic        app_dbi_ro_wr_disable;
    logic        cfg_busy;
    logic        lbc_dbi_ack;
    logic [31:0] lbc_dbi_dout;
    logic        dbi_halt;
    logic [7:0]  halt_cnt;

    modport master (
        output dbi_addr, dbi_din, dbi_cs, dbi_cs2, dbi_wr, app_dbi_ro_wr_disable, cfg_busy,
        input  lbc_dbi_ack, lbc_dbi_dout, dbi_halt, halt_cnt
    );

    modport slave (
        input  dbi_addr, dbi_din, dbi_cs, dbi_cs2, dbi_wr, app_dbi_ro_wr_disable, cfg_busy,
        output lbc_dbi_ack, lbc_dbi_dout, dbi_halt, halt_cnt
    );
endinterface

// File: rtl/ipsl_pcie_dbi_responder.sv
// rtl/ipsl_pcie_dbi_responder.sv - DBI shadow-register responder; optional bank 2 via IPSL_PCIE_DBI_BANK2_EN
module ipsl_pcie_dbi_responder #(
    parameter int          ACK_LAT  = 2,
    parameter int          RO_WORDS = 4,
    parameter logic [31:0] ID_VAL   = 32'h5A5A_0001
) (
    input  logic                          pclk_div2,
    input  logic                          apb_rst,
    ipsl_pcie_dbi_responder_if.slave      dbi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ACK_LAT - 1);
    localparam logic [6:0] RO_LIM = 7'(RO_WORDS);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_cs_q;
    logic        r_ack;
    logic [5:0]  r_word;
    logic        r_hit;
    logic [31:0] r_din;
    logic [3:0]  r_wr;
    logic        r_cs2;
    logic        r_ro_dis;
    logic [7:0]  r_halt_cnt;
    logic [31:0] r_bank1 [64];

    logic        w_cap;
    logic        w_halt;
    logic        w_ro_word;
    logic        w_commit;
    logic        w_commit1;
    logic        w_is_read;
    logic [31:0] w_rd_word;
    logic        w_unused_addr;

    // Only the cs rising edge in IDLE starts an access; a held-high cs is ignored.
    assign w_cap     = (r_state == S_IDLE) && dbi.dbi_cs && !r_cs_q;
    assign w_halt    = r_ack && dbi.cfg_busy;
    assign w_ro_word = !r_cs2 && ({1'b0, r_word} < RO_LIM);
    assign w_commit  = r_ack && !dbi.cfg_busy && r_hit && (|r_wr) && !(w_ro_word && r_ro_dis);
    assign w_commit1 = w_commit && !r_cs2;
    assign w_is_read = r_ack && !dbi.cfg_busy && r_hit && (r_wr == 4'd0);

    assign w_unused_addr = ^{dbi.dbi_addr[31:12], dbi.dbi_addr[1:0]};

`ifdef IPSL_PCIE_DBI_BANK2_EN
    logic [31:0] r_bank2 [64];
    logic        w_commit2;

    assign w_commit2 = w_commit && r_cs2;
    assign w_rd_word = r_cs2 ? r_bank2[r_word] : r_bank1[r_word];

    // Bank 2 (write-mask shadow): byte-lane writes, no read-only words.
    always_ff @(posedge pclk_div2) begin
        if (apb_rst) begin
            for (int i = 0; i < 64; i++) begin
                r_bank2[i] <= 32'd0;
            end
        end else if (w_commit2) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wr[b]) begin
                    r_bank2[r_word][8*b +: 8] <= r_din[8*b +: 8];
                end
            end
        end
    end
`else
    // Without bank 2, cs2 accesses read zero and their writes are dropped.
    assign w_rd_word = r_cs2 ? 32'd0 : r_bank1[r_word];
`endif

    // Request capture, latency count and one-cycle ack sequencing.
    always_ff @(posedge pclk_div2) begin
        if (apb_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_cs_q     <= 1'b0;
            r_ack      <= 1'b0;
            r_word     <= 6'd0;
            r_hit      <= 1'b0;
            r_din      <= 32'd0;
            r_wr       <= 4'd0;
            r_cs2      <= 1'b0;
            r_ro_dis   <= 1'b0;
            r_halt_cnt <= 8'd0;
        end else begin
            r_cs_q <= dbi.dbi_cs;
            r_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cap) begin
                        r_word   <= dbi.dbi_addr[7:2];
                        r_hit    <= (dbi.dbi_addr[11:8] == 4'd0);
                        r_din    <= dbi.dbi_din;
                        r_wr     <= dbi.dbi_wr;
                        r_cs2    <= dbi.dbi_cs2;
                        r_ro_dis <= dbi.app_dbi_ro_wr_disable;
                        r_cnt    <= LAT_M1;
                        if (LAT_M1 == 4'd0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    if (dbi.cfg_busy && (r_halt_cnt != 8'hFF)) begin
                        r_halt_cnt <= r_halt_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bank 1: word 0 resets to the ID value, commits land at the end of the ack cycle.
    always_ff @(posedge pclk_div2) begin
        if (apb_rst) begin
            for (int i = 0; i < 64; i++) begin
                r_bank1[i] <= (i == 0) ? ID_VAL : 32'd0;
            end
        end else if (w_commit1) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wr[b]) begin
                    r_bank1[r_word][8*b +: 8] <= r_din[8*b +: 8];
                end
            end
        end
    end

    assign dbi.lbc_dbi_ack  = r_ack;
    assign dbi.dbi_halt     = w_halt;
    assign dbi.lbc_dbi_dout = w_is_read ? w_rd_word : 32'd0;
    assign dbi.halt_cnt     = r_halt_cnt;

endmodule

// File: tb/tb_ipsl_pcie_dbi_responder.sv
// tb/tb_ipsl_pcie_dbi_responder.sv - directed bench for ipsl_pcie_dbi_responder (ACK_LAT 2 and 5 instances)
module tb_ipsl_pcie_dbi_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] model [64];
    localparam logic [31:0] ID = 32'h5A5A_0001;

    ipsl_pcie_dbi_responder_if ifa ();
    ipsl_pcie_dbi_responder_if ifb ();

    ipsl_pcie_dbi_responder u_a (
        .pclk_div2 (clk),
        .apb_rst   (rst),
        .dbi       (ifa)
    );

    ipsl_pcie_dbi_responder #(.ACK_LAT(5)) u_b (
        .pclk_div2 (clk),
        .apb_rst   (rst),
        .dbi       (ifb)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ifa.dbi_addr = 0; ifa.dbi_din = 0; ifa.dbi_cs = 0; ifa.dbi_cs2 = 0;
        ifa.dbi_wr = 0; ifa.app_dbi_ro_wr_disable = 0; ifa.cfg_busy = 0;
        ifb.dbi_addr = 0; ifb.dbi_din = 0; ifb.dbi_cs = 0; ifb.dbi_cs2 = 0;
        ifb.dbi_wr = 0; ifb.app_dbi_ro_wr_disable = 0; ifb.cfg_busy = 0;
    endtask

    // One full access: edge in cycle T, wait for ack (bounded), drop cs the cycle after ack.
    task automatic access(input bit b, input logic [31:0] addr, input logic [31:0] din,
                          input logic [3:0] wr, input logic cs2, input logic ro, input logic busy,
                          output logic [31:0] dout, output logic halt, output int lat);
        @(posedge clk); #1;
        if (b) begin
            ifb.dbi_addr = addr; ifb.dbi_din = din; ifb.dbi_wr = wr; ifb.dbi_cs2 = cs2;
            ifb.app_dbi_ro_wr_disable = ro; ifb.cfg_busy = busy; ifb.dbi_cs = 1'b1;
        end else begin
            ifa.dbi_addr = addr; ifa.dbi_din = din; ifa.dbi_wr = wr; ifa.dbi_cs2 = cs2;
            ifa.app_dbi_ro_wr_disable = ro; ifa.cfg_busy = busy; ifa.dbi_cs = 1'b1;
        end
        lat = -1; dout = 'x; halt = 'x;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if ((b ? ifb.lbc_dbi_ack : ifa.lbc_dbi_ack) === 1'b1) begin
                lat = k;
                dout = b ? ifb.lbc_dbi_dout : ifa.lbc_dbi_dout;
                halt = b ? ifb.dbi_halt : ifa.dbi_halt;
                break;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = (i == 0) ? ID : 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h; int l;
        do_reset();
        @(negedge clk);
        n_vec++; if (ifa.lbc_dbi_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ifa.lbc_dbi_ack); end
        n_vec++; if (ifa.lbc_dbi_dout !== 32'd0) begin n_err++; $display("FAIL reset_dout: got %h want 0", ifa.lbc_dbi_dout); end
        n_vec++; if (ifa.dbi_halt !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b want 0", ifa.dbi_halt); end
        n_vec++; if (ifa.halt_cnt !== 8'd0) begin n_err++; $display("FAIL reset_halt_cnt: got %0d want 0", ifa.halt_cnt); end
        access(0, 32'h000, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (l !== 2) begin n_err++; $display("FAIL reset_read_lat: got %0d want 2", l); end
        n_vec++; if (d !== ID) begin n_err++; $display("FAIL reset_read_dout: got %h want %h", d, ID); end
        n_vec++; if (h !== 1'b0) begin n_err++; $display("FAIL reset_read_halt: got %b want 0", h); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] d; logic h; int l;
        access(0, 32'h010, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'd0 || l !== 2) begin n_err++; $display("FAIL bl_write_ack: got dout %h lat %0d want 0 / 2", d, l); end
        model[4] = 32'h00AD_00EF;
        access(0, 32'h010, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'h00AD_00EF) begin n_err++; $display("FAIL bl_readback: got %h want 00ad00ef", d); end
    endtask

    task automatic test_read_only();
        logic [31:0] d; logic h; int l;
        access(0, 32'h004, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, d, h, l);
        access(0, 32'h004, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ro_blocked: got %h want 0", d); end
        access(0, 32'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, d, h, l);
        model[1] = 32'hFFFF_FFFF;
        access(0, 32'h004, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ro_allowed: got %h want ffffffff", d); end
    endtask

    task automatic test_halt();
        logic [31:0] d; logic h; int l;
        access(0, 32'h020, 32'h1234_5678, 4'hF, 0, 0, 1, d, h, l);
        n_vec++; if (h !== 1'b1 || l !== 2) begin n_err++; $display("FAIL halt_flag: got halt %b lat %0d want 1 / 2", h, l); end
        n_vec++; if (ifa.halt_cnt !== 8'd1) begin n_err++; $display("FAIL halt_cnt1: got %0d want 1", ifa.halt_cnt); end
        access(0, 32'h020, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'd0 || h !== 1'b0) begin n_err++; $display("FAIL halt_no_commit: got %h halt %b want 0 / 0", d, h); end
        access(0, 32'h000, 0, 4'h0, 0, 0, 1, d, h, l);
        n_vec++; if (d !== 32'd0 || h !== 1'b1) begin n_err++; $display("FAIL halt_read_dout: got %h halt %b want 0 / 1", d, h); end
        n_vec++; if (ifa.halt_cnt !== 8'd2) begin n_err++; $display("FAIL halt_cnt2: got %0d want 2", ifa.halt_cnt); end
        access(0, 32'h020, 32'h1234_5678, 4'hF, 0, 0, 0, d, h, l);
        model[8] = 32'h1234_5678;
        access(0, 32'h020, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL halt_retry: got %h want 12345678", d); end
    endtask

    task automatic test_early_release();
        logic [31:0] d; logic h; int l;
        int got;
        got = -1;
        @(posedge clk); #1;
        ifa.dbi_addr = 32'h030; ifa.dbi_din = 32'h0000_00C3; ifa.dbi_wr = 4'b0001; ifa.dbi_cs = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ifa.lbc_dbi_ack === 1'b1) begin got = k; break; end
        end
        n_vec++; if (got !== 2) begin n_err++; $display("FAIL early_release_lat: got %0d want 2", got); end
        model[12] = 32'h0000_00C3;
        access(0, 32'h030, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'h0000_00C3) begin n_err++; $display("FAIL early_release_data: got %h want 000000c3", d); end
    endtask

    task automatic test_hold();
        int got; int extra;
        got = -1; extra = 0;
        @(posedge clk); #1;
        ifa.dbi_addr = 32'h010; ifa.dbi_cs = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (ifa.lbc_dbi_ack === 1'b1) begin got = k; break; end
        end
        n_vec++; if (got !== 2) begin n_err++; $display("FAIL hold_first_ack: got lat %0d want 2", got); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ifa.lbc_dbi_ack !== 1'b0) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL hold_no_reack: got %0d extra acks want 0", extra); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic h; int l;
        access(0, 32'h03C, 32'h0000_0077, 4'hF, 0, 0, 0, d, h, l);
        model[15] = 32'h0000_0077;
        access(0, 32'h03C, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'h0000_0077 || l !== 2) begin n_err++; $display("FAIL b2b_read: got %h lat %0d want 00000077 / 2", d, l); end
    endtask

    task automatic test_miss();
        logic [31:0] d; logic h; int l;
        int bad;
        access(0, 32'h104, 32'h0BAD_F00D, 4'hF, 0, 0, 0, d, h, l);
        n_vec++; if (l !== 2 || d !== 32'd0) begin n_err++; $display("FAIL miss_write_ack: got lat %0d dout %h want 2 / 0", l, d); end
        access(0, 32'h110, 32'h0BAD_F00D, 4'hF, 0, 0, 0, d, h, l);
        access(0, 32'h104, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (l !== 2 || d !== 32'd0) begin n_err++; $display("FAIL miss_read: got lat %0d dout %h want 2 / 0", l, d); end
        bad = 0;
        for (int w = 0; w < 64; w++) begin
            access(0, 32'(w * 4), 0, 4'h0, 0, 0, 0, d, h, l);
            n_vec++;
            if (d !== model[w]) begin n_err++; bad++; $display("FAIL miss_scan_w%0d: got %h want %h", w, d, model[w]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic h; int l;
        int acks;
        acks = 0;
        @(posedge clk); #1;
        ifa.dbi_addr = 32'h040; ifa.dbi_din = 32'h0000_0001; ifa.dbi_wr = 4'hF; ifa.dbi_cs = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        if (ifa.lbc_dbi_ack !== 1'b0) acks++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = (i == 0) ? ID : 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.lbc_dbi_ack !== 1'b0) acks++;
        end
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
        n_vec++; if (ifa.halt_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_halt_cnt: got %0d want 0", ifa.halt_cnt); end
        access(0, 32'h040, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rstmid_no_commit: got %h want 0", d); end
        access(0, 32'h010, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rstmid_word4: got %h want 0", d); end
        access(0, 32'h000, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== ID) begin n_err++; $display("FAIL rstmid_word0: got %h want %h", d, ID); end
    endtask

    task automatic test_bank2();
        logic [31:0] d; logic h; int l;
        logic [31:0] exp2;
`ifdef IPSL_PCIE_DBI_BANK2_EN
        exp2 = 32'hA5A5_A5A5;
`else
        exp2 = 32'd0;
`endif
        access(1, 32'h000, 32'hA5A5_A5A5, 4'hF, 1, 0, 0, d, h, l);
        n_vec++; if (l !== 5) begin n_err++; $display("FAIL b2_write_lat: got %0d want 5", l); end
        n_vec++; if (d !== 32'd0 || h !== 1'b0) begin n_err++; $display("FAIL b2_write_ack: got dout %h halt %b want 0 / 0", d, h); end
        access(1, 32'h000, 0, 4'h0, 1, 0, 0, d, h, l);
        n_vec++; if (d !== exp2 || l !== 5) begin n_err++; $display("FAIL b2_read: got %h lat %0d want %h / 5", d, l, exp2); end
        access(1, 32'h000, 0, 4'h0, 0, 0, 0, d, h, l);
        n_vec++; if (d !== ID) begin n_err++; $display("FAIL b2_bank1_word0: got %h want %h", d, ID); end
        access(1, 32'h000, 32'h0000_FFFF, 4'hF, 1, 0, 1, d, h, l);
        n_vec++; if (h !== 1'b1 || ifb.halt_cnt !== 8'd1) begin n_err++; $display("FAIL b2_halt: got halt %b cnt %0d want 1 / 1", h, ifb.halt_cnt); end
        access(1, 32'h000, 0, 4'h0, 1, 0, 0, d, h, l);
        n_vec++; if (d !== exp2) begin n_err++; $display("FAIL b2_halt_no_commit: got %h want %h", d, exp2); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_byte_lane();
        test_read_only();
        test_halt();
        test_early_release();
        test_hold();
        test_back_to_back();
        test_miss();
        test_reset_mid();
        test_bank2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
